// File: rtl/key_capture_conditioner.sv
// Push-button synchronizer/debouncer with switch-word capture on KEY0 and mode toggle on KEY1.
// Optional KEY_AUTOREPEAT_EN adds auto-repeat of KEY0 while it is held.
module key_capture_conditioner #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned W           = 10,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic [W-1:0] SW,
    input  logic [1:0]   KEY,
    output logic [W-1:0] value_q,
    output logic         mode_unsigned,
    output logic [1:0]   key_pulse,
    output logic         valid
);

    localparam int unsigned DEB_RAW    = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DEB_CYCLES = (DEB_RAW < 1) ? 1 : DEB_RAW;
    localparam int unsigned CW         = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    logic [1:0]    rst_sync_q;
    logic          rst_int_n;
    logic [W-1:0]  sw_meta_q, sw_sync_q;
    logic [1:0]    key_meta_q, key_sync_q;
    logic [1:0]    press;
    key_state_e    state_q [2];
    key_state_e    state_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [1:0]    fsm_pulse;
    logic          rpt_fire;
    logic [1:0]    pulse_d, pulse_q;
    logic [W-1:0]  value_d;
    logic          mode_d, mode_q;
    logic          valid_d, valid_q;

    // Reset asserts immediately but leaves reset only on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '1;
            key_sync_q <= '1;
        end else begin
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
        end
    end

    assign press = ~key_sync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fsm_pulse = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            case (state_q[i])
                RELEASED: begin
                    if (press[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!press[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                        state_d[i]   = PRESSED;
                        cnt_d[i]     = '0;
                        fsm_pulse[i] = 1'b1;
                    end else if (cnt_q[i] != CW'(DEB_CYCLES)) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!press[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (press[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != CW'(DEB_CYCLES)) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_RAW    = CLK_HZ / 1000 * REPEAT_MS;
    localparam int unsigned RPT_CYCLES = (RPT_RAW < 1) ? 1 : RPT_RAW;
    localparam int unsigned RW         = $clog2(2 * RPT_CYCLES);

    logic [RW-1:0] rpt_q, rpt_d;

    // First repeat after 2*period in PRESSED, then every period (counter reloads to mid-point).
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q[0] == PRESSED && press[0]) begin
            if (rpt_q == RW'(2 * RPT_CYCLES - 1)) begin
                rpt_d    = RW'(RPT_CYCLES);
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) rpt_q <= '0;
        else            rpt_q <= rpt_d;
    end
`else
    if (REPEAT_MS == 0) begin : g_repeat_unused
    end
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        pulse_d = fsm_pulse | {1'b0, rpt_fire};
        value_d = pulse_d[0] ? sw_sync_q : value_q;
        mode_d  = mode_q ^ pulse_d[1];
        valid_d = pulse_d[0];
    end

    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
            value_q <= '0;
            mode_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q <= pulse_d;
            value_q <= value_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign key_pulse     = pulse_q;
    assign mode_unsigned = mode_q;
    assign valid         = valid_q;

endmodule
